// File: rtl/ps2_key_tracker.sv
// PS/2 scancode tracker: pops bytes from a receiver FIFO, decodes E0/F0
// prefixes, tracks the held key and counts new presses, and drives a
// seven-segment display with the key code and the press count.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | no prefix pending; next plain byte is a make
// ST_EXT     | E0 seen; next plain byte is an extended make
// ST_BRK     | F0 seen; next plain byte is a break
// ST_EXT_BRK | E0 and F0 seen; next plain byte is an extended break
module ps2_key_tracker #(
    parameter int NUM_DIGITS       = 6,
    parameter int CNT_WIDTH        = 8,
    parameter bit BLANK_ON_RELEASE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              kb_data,
    input  logic                    kb_ready,
    input  logic                    kb_overflow,
    output logic                    kb_nextdata_n,
    output logic [7:0]              key_code,
    output logic                    key_ext,
    output logic                    key_down,
    output logic                    key_event,
    output logic [CNT_WIDTH-1:0]    press_count,
    output logic                    err_overflow,
    output logic [NUM_DIGITS*7-1:0] hex
);

    localparam int CNT_DIG_W = (NUM_DIGITS - 2) * 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t               state_q, state_d, state_eff;
    logic                 gap_q, gap_d;
    logic                 nextdata_n_q, nextdata_n_d;
    logic [7:0]           key_code_q, key_code_d;
    logic                 key_ext_q, key_ext_d;
    logic                 key_down_q, key_down_d;
    logic                 key_event_q, key_event_d;
    logic [CNT_WIDTH-1:0] press_count_q, press_count_d;
    logic                 err_overflow_q, err_overflow_d;

    logic pop, is_e0, is_f0, in_ext, in_brk, is_make, is_break, matches_held;

    // Byte acceptance and prefix classification; overflow drops any pending prefix.
    always_comb begin
        pop          = kb_ready & ~gap_q;
        state_eff    = kb_overflow ? ST_IDLE : state_q;
        is_e0        = (kb_data == 8'hE0);
        is_f0        = (kb_data == 8'hF0);
        in_ext       = (state_eff == ST_EXT) || (state_eff == ST_EXT_BRK);
        in_brk       = (state_eff == ST_BRK) || (state_eff == ST_EXT_BRK);
        is_make      = pop & ~is_e0 & ~is_f0 & ~in_brk;
        is_break     = pop & ~is_e0 & ~is_f0 & in_brk;
        matches_held = (key_code_q == kb_data) && (key_ext_q == in_ext);
    end

    // Prefix state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Prefix next-state: E0 adds the extended flag, F0 adds the break flag.
    always_comb begin
        state_d = state_eff;
        if (pop) begin
            if (is_e0)      state_d = in_brk ? ST_EXT_BRK : ST_EXT;
            else if (is_f0) state_d = in_ext ? ST_EXT_BRK : ST_BRK;
            else            state_d = ST_IDLE;
        end
    end

    // Key tracking outputs; a make identical to the held key is typematic and ignored.
    always_comb begin
        gap_d          = pop;
        nextdata_n_d   = ~pop;
        key_code_d     = key_code_q;
        key_ext_d      = key_ext_q;
        key_down_d     = key_down_q;
        key_event_d    = 1'b0;
        press_count_d  = press_count_q;
        err_overflow_d = err_overflow_q | kb_overflow;
        if (is_make && !(key_down_q && matches_held)) begin
            key_code_d    = kb_data;
            key_ext_d     = in_ext;
            key_down_d    = 1'b1;
            key_event_d   = 1'b1;
            press_count_d = press_count_q + 1'b1;
        end
        if (is_break && matches_held) key_down_d = 1'b0;
    end

    // Output and handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_q          <= 1'b0;
            nextdata_n_q   <= 1'b1;
            key_code_q     <= 8'h00;
            key_ext_q      <= 1'b0;
            key_down_q     <= 1'b0;
            key_event_q    <= 1'b0;
            press_count_q  <= '0;
            err_overflow_q <= 1'b0;
        end else begin
            gap_q          <= gap_d;
            nextdata_n_q   <= nextdata_n_d;
            key_code_q     <= key_code_d;
            key_ext_q      <= key_ext_d;
            key_down_q     <= key_down_d;
            key_event_q    <= key_event_d;
            press_count_q  <= press_count_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign kb_nextdata_n = nextdata_n_q;
    assign key_code      = key_code_q;
    assign key_ext       = key_ext_q;
    assign key_down      = key_down_q;
    assign key_event     = key_event_q;
    assign press_count   = press_count_q;
    assign err_overflow  = err_overflow_q;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [CNT_DIG_W-1:0] cnt_disp;
    assign cnt_disp = CNT_DIG_W'(press_count_q);

    // Display decode from registered state only.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        if (g < 2) begin : g_key
            assign hex[7*g +: 7] = (BLANK_ON_RELEASE && !key_down_q) ? 7'h7F
                                                                     : seg7(key_code_q[4*g +: 4]);
        end else begin : g_cnt
            assign hex[7*g +: 7] = seg7(cnt_disp[4*(g-2) +: 4]);
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: a FIFO model feeds bytes, a reference
// model predicts the result of each byte, and a monitor checks after every pop.
module tb_ps2_key_tracker;

    localparam int ND = 6;
    localparam int CW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        kb_data;
    logic              kb_ready;
    logic              kb_overflow;
    logic              kb_nextdata_n;
    logic [7:0]        key_code;
    logic              key_ext;
    logic              key_down;
    logic              key_event;
    logic [CW-1:0]     press_count;
    logic              err_overflow;
    logic [ND*7-1:0]   hex;

    ps2_key_tracker #(.NUM_DIGITS(ND), .CNT_WIDTH(CW), .BLANK_ON_RELEASE(1'b1)) dut (
        .clk(clk), .rst(rst), .kb_data(kb_data), .kb_ready(kb_ready),
        .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n),
        .key_code(key_code), .key_ext(key_ext), .key_down(key_down),
        .key_event(key_event), .press_count(press_count),
        .err_overflow(err_overflow), .hex(hex)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       down;
        logic [7:0] cnt;
        logic       ev;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    int         pop_cyc[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         ev_seen = 0;
    logic       prev_low = 1'b0;

    // reference model: held key plus pending prefix flags
    logic [7:0] m_code;
    logic       m_kext, m_down, m_err, m_pext, m_pbrk;
    logic [7:0] m_cnt;
    int         m_events;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return ~t[n];
    endfunction

    function automatic logic [ND*7-1:0] exp_hex(input logic [7:0] code, input logic down,
                                                input logic [7:0] cnt);
        logic [ND*7-1:0] r;
        logic [15:0]     c16;
        c16     = {8'h00, cnt};
        r[6:0]  = down ? seg(code[3:0]) : 7'h7F;
        r[13:7] = down ? seg(code[7:4]) : 7'h7F;
        for (int i = 0; i < ND - 2; i++) r[7*(i+2) +: 7] = seg(c16[4*i +: 4]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic m_reset();
        m_code = 8'h00; m_kext = 1'b0; m_down = 1'b0; m_err = 1'b0;
        m_pext = 1'b0;  m_pbrk = 1'b0; m_cnt = 8'h00;
    endtask

    task automatic m_byte(input logic [7:0] b);
        exp_t e;
        logic ev;
        ev = 1'b0;
        if (b == 8'hE0) m_pext = 1'b1;
        else if (b == 8'hF0) m_pbrk = 1'b1;
        else begin
            if (!m_pbrk) begin
                if (!(m_down && m_code == b && m_kext == m_pext)) begin
                    m_code = b; m_kext = m_pext; m_down = 1'b1;
                    m_cnt  = m_cnt + 8'd1; ev = 1'b1; m_events++;
                end
            end else if (m_code == b && m_kext == m_pext) begin
                m_down = 1'b0;
            end
            m_pext = 1'b0; m_pbrk = 1'b0;
        end
        e.code = m_code; e.ext = m_kext; e.down = m_down;
        e.cnt = m_cnt; e.ev = ev; e.err = m_err;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        m_byte(b);
        fifo_q.push_back(b);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) begin
            total++; bad++;
            $display("FAIL drain_timeout: fifo=%0d pending=%0d", fifo_q.size(), exp_q.size());
            fifo_q.delete(); exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; m_reset();
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_nextdata_n"}, kb_nextdata_n, 1'b1);
        chk({tag, "_key_code"}, key_code, 8'h00);
        chk({tag, "_key_ext"}, key_ext, 1'b0);
        chk({tag, "_key_down"}, key_down, 1'b0);
        chk({tag, "_key_event"}, key_event, 1'b0);
        chk({tag, "_press_count"}, press_count, 8'h00);
        chk({tag, "_err_overflow"}, err_overflow, 1'b0);
        chk({tag, "_hex"}, hex, exp_hex(8'h00, 1'b0, 8'h00));
    endtask

    // FIFO model: removes the head while the pop strobe is low
    initial begin
        kb_ready = 1'b0;
        kb_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!kb_nextdata_n && fifo_q.size() > 0) void'(fifo_q.pop_front());
            kb_ready = (fifo_q.size() > 0);
            kb_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        end
    end

    // monitor: every pop strobe means one byte was decoded at the preceding edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (key_event) ev_seen++;
            if (!kb_nextdata_n) begin
                chk("pop_spacing", prev_low, 1'b0);
                pop_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_pop: pop with no byte issued (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("key_code", key_code, e.code);
                    chk("key_ext", key_ext, e.ext);
                    chk("key_down", key_down, e.down);
                    chk("press_count", press_count, e.cnt);
                    chk("key_event", key_event, e.ev);
                    chk("err_overflow", err_overflow, e.err);
                    chk("hex", hex, exp_hex(e.code, e.down, e.cnt));
                end
                prev_low = 1'b1;
            end else begin
                prev_low = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ev0, m0;
        logic [7:0] pool [8];
        pool = '{8'hE0, 8'hF0, 8'h1C, 8'h32, 8'h75, 8'h1C, 8'h32, 8'h23};
        m_events    = 0;
        rst         = 1'b1;
        kb_overflow = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);

        // byte waiting in the FIFO during reset must not be popped
        send(8'h1C);
        repeat (3) @(negedge clk);
        chk_reset_vals("in_reset");
        rst = 1'b0;
        send(8'hF0);
        send(8'h1C);
        drain(400);
        chk("make_break_code", key_code, 8'h1C);
        chk("make_break_down", key_down, 1'b0);
        chk("make_break_count", press_count, 8'd1);
        chk("make_break_events", ev_seen, 1);
        chk("make_break_blank", hex[6:0], 7'h7F);

        // extended make and extended break
        do_reset();
        ev0 = ev_seen;
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        drain(400);
        chk("ext_key_ext", key_ext, 1'b1);
        chk("ext_key_code", key_code, 8'h75);
        chk("ext_count", press_count, 8'd1);
        chk("ext_down", key_down, 1'b0);
        send(8'h1C);
        drain(400);
        chk("ext_then_plain_ext", key_ext, 1'b0);

        // typematic repeats
        do_reset();
        ev0 = ev_seen;
        repeat (5) send(8'h1C);
        drain(400);
        chk("typematic_count", press_count, 8'd1);
        chk("typematic_events", ev_seen - ev0, 1);

        // continuous kb_ready: pops every second cycle
        pop_cyc.delete();
        for (int i = 0; i < 12; i++) send(pool[2 + $urandom_range(0, 5)]);
        drain(400);
        chk("burst_pops", pop_cyc.size(), 12);
        for (int i = 1; i < pop_cyc.size(); i++)
            chk("burst_spacing", pop_cyc[i] - pop_cyc[i-1], 2);

        // overflow discards a pending E0 and is sticky
        do_reset();
        send(8'hE0);
        drain(400);
        @(negedge clk); kb_overflow = 1'b1;
        @(negedge clk); kb_overflow = 1'b0;
        m_err = 1'b1; m_pext = 1'b0; m_pbrk = 1'b0;
        chk("overflow_set", err_overflow, 1'b1);
        send(8'h1C);
        drain(400);
        chk("overflow_ext", key_ext, 1'b0);
        chk("overflow_code", key_code, 8'h1C);

        // random traffic with idle gaps
        ev0 = ev_seen;
        m0  = m_events;
        for (int i = 0; i < 300; i++) begin
            send(pool[$urandom_range(0, 7)]);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain(2000);
        chk("random_events", ev_seen - ev0, m_events - m0);
        chk("overflow_sticky", err_overflow, 1'b1);

        // reset in the middle of an E0 prefix
        send(8'hE0);
        drain(400);
        @(negedge clk); rst = 1'b1;
        #1;
        chk_reset_vals("mid_prefix");
        m_reset();
        @(negedge clk); rst = 1'b0;
        send(8'h1C);
        drain(400);
        chk("after_rst_ext", key_ext, 1'b0);
        chk("after_rst_count", press_count, 8'd1);

        // counter wrap after 256 distinct makes
        do_reset();
        ev0 = ev_seen;
        for (int i = 0; i < 256; i++) send((i % 2 == 0) ? 8'h1C : 8'h32);
        drain(2000);
        chk("wrap_count", press_count, 8'h00);
        chk("wrap_digits", hex[27:14], {seg(4'h0), seg(4'h0)});
        chk("wrap_events", ev_seen - ev0, 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, meaning the count of seven-segment digits driven; legal values are even, 4..8.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, meaning the press-counter width; legal range is 8..(NUM_DIGITS-2)*4.
REQ-003 SHALL have parameter BLANK_ON_RELEASE, default 1, meaning key-code digits are blanked while no key is held.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port kb_data, input, 8 bits: scancode byte from the PS/2 receiver FIFO.
REQ-007 SHALL have port kb_ready, input, 1 bit: the FIFO is non-empty and kb_data is valid.
REQ-008 SHALL have port kb_overflow, input, 1 bit: the FIFO has dropped bytes.
REQ-009 SHALL have port kb_nextdata_n, output, 1 bit: active-low pop strobe to the FIFO.
REQ-010 SHALL have port key_code, output, 8 bits: the last make code.
REQ-011 SHALL have port key_ext, output, 1 bit: the last make was E0-prefixed.
REQ-012 SHALL have port key_down, output, 1 bit: key_code/key_ext is currently held.
REQ-013 SHALL have port key_event, output, 1 bit: one-cycle pulse on each counted new press.
REQ-014 SHALL have port press_count, output, CNT_WIDTH bits: the count of new presses.
REQ-015 SHALL have port err_overflow, output, 1 bit: sticky FIFO-overflow flag.
REQ-016 SHALL have port hex, output, NUM_DIGITS*7 bits: active-low segments, digit i at bits [7i+6:7i], segment a at bit 0.

Function
REQ-017 SHALL pop a byte at a rising edge where kb_ready=1 and gap=0; kb_nextdata_n SHALL be 0 for exactly the following cycle.
REQ-018 SHALL set gap=1 for the cycle after a pop, so kb_ready is not sampled then; back-to-back pops are therefore at least 2 cycles apart.
REQ-019 SHALL hold a prefix FSM with the states IDLE, EXT, BRK and EXT_BRK; all decode effects SHALL take place at the pop edge (zero added latency).
REQ-020 SHALL handle a popped byte E0 by moving to EXT from IDLE/EXT, or to EXT_BRK from BRK/EXT_BRK.
REQ-021 SHALL handle a popped byte F0 by moving to BRK from IDLE/BRK, or to EXT_BRK from EXT/EXT_BRK.
REQ-022 SHALL treat any other byte in IDLE/EXT as a make, with ext = (state==EXT), and then return to IDLE.
REQ-023 SHALL treat a make equal to a held key (key_down=1, same code, same ext) as a typematic repeat: no change, no count, no key_event.
REQ-024 SHALL handle any other make with: key_code<=byte, key_ext<=ext, key_down<=1, press_count<=press_count+1 (modulo 2^CNT_WIDTH, wraps silently), key_event=1 for one cycle.
REQ-025 SHALL treat any other byte in BRK/EXT_BRK as a break; if it matches key_code/key_ext, key_down<=0, otherwise no change; then return to IDLE.
REQ-026 SHALL handle kb_overflow=1 at an edge by setting err_overflow, with only reset clearing it.
REQ-027 SHALL, when kb_overflow=1 at an edge, decode any byte popped at that same edge from IDLE, discarding the pending prefix.
REQ-028 SHALL drive digits 1:0 with key_code as hex (digit 0 = low nibble).
REQ-029 SHALL drive digits 1:0 all-ones (blank) when BLANK_ON_RELEASE=1 and key_down=0.
REQ-030 SHALL drive digits NUM_DIGITS-1:2 with press_count, zero-extended, as hex.
REQ-031 SHALL make hex a combinational decode of registered state only (no input-to-output path).

Reset
REQ-032 SHALL, while rst=1 and independent of clk, force: kb_nextdata_n=1, gap=0, FSM=IDLE, key_code=00, key_ext=0, key_down=0, key_event=0, press_count=0, err_overflow=0.
REQ-033 SHALL, when rst asserts mid-sequence (e.g. after E0), discard the prefix, and the first byte after release SHALL decode from IDLE.
REQ-034 SHALL not pop while rst=1, and SHALL pop no earlier than the first edge after rst deasserts.

Verification
REQ-035 SHALL cover: bytes 1C, F0, 1C → key_code=1C, key_down 1→0, press_count=1, one key_event, hex[6:0]=blank after the break.
REQ-036 SHALL cover: bytes E0, 75, E0, F0, 75 → key_ext=1, key_code=75, press_count=1, final key_down=0, FSM=IDLE.
REQ-037 SHALL cover: bytes 1C ×5 (typematic) → press_count=1, exactly one key_event.
REQ-038 SHALL cover: kb_ready held high continuously → kb_nextdata_n low pulses exactly every 2nd cycle, never two consecutive lows.
REQ-039 SHALL cover: CNT_WIDTH=8 with 256 distinct makes (alternating 1C/32) → press_count wraps to 00, digits 3:2 show "00".
REQ-040 SHALL cover: E0 popped, kb_overflow=1 pulse, then 1C → err_overflow=1 (sticky), key_ext=0; rst mid-E0 prefix → all outputs at reset values and the next 1C decodes as key_ext=0.
